// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: multiplicand, product/multiplier register,
// add carry and saturating iteration counter driven by a write/add/sr word.
module mult_datapath #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [WIDTH-1:0]   multiplicand_in,
   input  logic [WIDTH-1:0]   multiplier_in,
   input  logic               write,
   input  logic               add,
   input  logic               sr,
   output logic               p0,
   output logic               is_less,
   output logic [2*WIDTH-1:0] product,
   output logic [CNT_W-1:0]   count
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   logic [WIDTH-1:0]   r_m;
   logic [2*WIDTH-1:0] r_p;
   logic               r_c;
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH-1:0]   w_m_nxt;
   logic [2*WIDTH-1:0] w_p_nxt;
   logic               w_c_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [WIDTH:0]     w_sum;
   logic [CNT_W-1:0]   w_cnt_inc;

   assign w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m};

   // Counter stops at WIDTH so is_less stays low on extra shifts
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

   always_comb begin
      w_m_nxt   = r_m;
      w_p_nxt   = r_p;
      w_c_nxt   = r_c;
      w_cnt_nxt = r_cnt;
      if (load) begin
         w_m_nxt   = multiplicand_in;
         w_p_nxt   = {{WIDTH{1'b0}}, multiplier_in};
         w_c_nxt   = 1'b0;
         w_cnt_nxt = '0;
      end else if (write) begin
         unique case ({add, sr})
            2'b10: begin
               w_c_nxt                    = w_sum[WIDTH];
               w_p_nxt[2*WIDTH-1:WIDTH]   = w_sum[WIDTH-1:0];
            end
            2'b01: begin
               w_p_nxt   = {r_c, r_p[2*WIDTH-1:1]};
               w_c_nxt   = 1'b0;
               w_cnt_nxt = w_cnt_inc;
            end
            2'b11: begin
               w_p_nxt   = {w_sum, r_p[WIDTH-1:1]};
               w_c_nxt   = 1'b0;
               w_cnt_nxt = w_cnt_inc;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m   <= '0;
         r_p   <= '0;
         r_c   <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_m   <= w_m_nxt;
         r_p   <= w_p_nxt;
         r_c   <= w_c_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   assign p0      = r_p[0];
   assign is_less = (r_cnt < CNT_MAX);
   assign product = r_p;
   assign count   = r_cnt;

endmodule

// File: tb/tb_mult_datapath.sv
// Bench for mult_datapath: vector tables, hand corner sequences and
// random ops against an arithmetic reference model.
module tb_mult_datapath;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load = 1'b0;
   logic          write = 1'b0;
   logic          add = 1'b0;
   logic          sr = 1'b0;
   logic [W-1:0]  mi = '0;
   logic [W-1:0]  qi = '0;
   logic          p0;
   logic          is_less;
   logic [2*W-1:0] product;
   logic [CW-1:0] count;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state: plain integers
   int mm, mp, mc, mcnt;

   always #5 clk = ~clk;

   mult_datapath #(.WIDTH(W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .load            (load),
      .multiplicand_in (mi),
      .multiplier_in   (qi),
      .write           (write),
      .add             (add),
      .sr              (sr),
      .p0              (p0),
      .is_less         (is_less),
      .product         (product),
      .count           (count)
   );

   typedef struct {
      bit       ld, wr, ad, s;
      int       m, q;
      int       exp_p, exp_cnt;
   } vec_t;

   typedef struct {
      int m, q, exp_p;
   } mul_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      mm = 0; mp = 0; mc = 0; mcnt = 0;
   endtask

   task automatic model_op(input bit ld, wr, ad, s, input int m, q);
      int up, v;
      if (ld) begin
         mm = m; mp = q; mc = 0; mcnt = 0;
      end else if (wr && (ad || s)) begin
         up = mp / 256 + mm;
         if (ad && !s) begin
            mc = up / 256;
            mp = (up % 256) * 256 + mp % 256;
         end else begin
            v  = ad ? up * 256 + mp % 256 : mc * 65536 + mp;
            mp = v / 2;
            mc = 0;
            mcnt = (mcnt + 1 > W) ? W : mcnt + 1;
         end
      end
   endtask

   task automatic check_model(input string nm);
      chk({nm, ".product"}, 32'(product), 32'(mp));
      chk({nm, ".p0"},      32'(p0),      32'(mp % 2));
      chk({nm, ".is_less"}, 32'(is_less), 32'(mcnt < W));
      chk({nm, ".count"},   32'(count),   32'(mcnt));
   endtask

   task automatic op(input bit ld, wr, ad, s, input int m, q);
      @(negedge clk);
      load = ld; write = wr; add = ad; sr = s;
      mi = W'(m); qi = W'(q);
      @(posedge clk);
      #1;
      load = 0; write = 0; add = 0; sr = 0;
      model_op(ld, wr, ad, s, m, q);
   endtask

   vec_t vt[$];
   mul_t mt[$];

   initial begin
      vt = '{
         '{1, 0, 0, 0, 'hFF, 'h01, 'h0001, 0},
         '{0, 1, 1, 0, 0,    0,    'hFF01, 0},
         '{0, 1, 1, 0, 0,    0,    'hFE01, 0},
         '{0, 1, 0, 1, 0,    0,    'hFF00, 1},
         '{1, 1, 1, 1, 'h05, 'h03, 'h0003, 0},
         '{0, 0, 1, 1, 0,    0,    'h0003, 0},
         '{0, 1, 0, 0, 0,    0,    'h0003, 0},
         '{0, 1, 0, 1, 0,    0,    'h0001, 1},
         '{0, 1, 1, 1, 0,    0,    'h0280, 2}
      };
      mt = '{
         '{13, 11, 'h008F},
         '{'hFF, 'hFF, 'hFE01},
         '{0, 'hFF, 0},
         '{'hFF, 0, 0},
         '{1, 1, 1},
         '{'h80, 2, 'h0100}
      };
      model_reset();

      // reset state before any clock edge
      #2;
      chk("rst.product", 32'(product), 0);
      chk("rst.p0",      32'(p0),      0);
      chk("rst.is_less", 32'(is_less), 1);
      chk("rst.count",   32'(count),   0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed vectors: separate ops, priority, hold
      foreach (vt[i]) begin
         op(vt[i].ld, vt[i].wr, vt[i].ad, vt[i].s, vt[i].m, vt[i].q);
         chk($sformatf("vec%0d.product", i), 32'(product), 32'(vt[i].exp_p));
         chk($sformatf("vec%0d.count", i),   32'(count),   32'(vt[i].exp_cnt));
         check_model($sformatf("vec%0d", i));
      end

      // full multiplies, controller loop driven by p0
      foreach (mt[i]) begin
         op(1, 0, 0, 0, mt[i].m, mt[i].q);
         for (int k = 0; k < W; k++) begin
            if (k == W - 1)
               chk($sformatf("mul%0d.less_before_last", i), 32'(is_less), 1);
            op(0, 1, p0, 1, 0, 0);
         end
         chk($sformatf("mul%0d.product", i), 32'(product), 32'(mt[i].exp_p));
         chk($sformatf("mul%0d.count", i),   32'(count),   W);
         chk($sformatf("mul%0d.is_less", i), 32'(is_less), 0);
      end

      // saturation: ten shifts after load
      op(1, 0, 0, 0, 'h5A, 'hFF);
      for (int k = 1; k <= 10; k++) begin
         op(0, 1, 0, 1, 0, 0);
         chk($sformatf("sat%0d.count", k), 32'(count), 32'((k > W) ? W : k));
         chk($sformatf("sat%0d.product", k), 32'(product), 32'('hFF >> k));
         chk($sformatf("sat%0d.is_less", k), 32'(is_less), 32'(k < W));
      end

      // asynchronous reset during the 4th iteration
      op(1, 0, 0, 0, 13, 11);
      for (int k = 0; k < 3; k++) op(0, 1, p0, 1, 0, 0);
      @(negedge clk);
      write = 1; add = p0; sr = 1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst.product", 32'(product), 0);
      chk("arst.count",   32'(count),   0);
      chk("arst.is_less", 32'(is_less), 1);
      chk("arst.p0",      32'(p0),      0);
      @(posedge clk);
      #1;
      write = 0; add = 0; sr = 0;
      model_reset();
      check_model("arst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      op(0, 1, 1, 1, 0, 0);
      check_model("arst_after");

      // random ops against the model
      for (int n = 0; n < 300; n++) begin
         bit ld, wr, ad, s;
         ld = ($urandom_range(0, 9) == 0);
         wr = $urandom_range(0, 3) != 0;
         ad = 1'($urandom);
         s  = 1'($urandom);
         op(ld, wr, ad, s, $urandom_range(0, 255), $urandom_range(0, 255));
         check_model($sformatf("rnd%0d", n));
      end

      // random full multiplies against M*Q
      for (int n = 0; n < 30; n++) begin
         int a, b;
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         op(1, 0, 0, 0, a, b);
         for (int k = 0; k < W; k++) op(0, 1, p0, 1, 0, 0);
         chk($sformatf("rmul%0d.product", n), 32'(product), 32'(a * b));
         check_model($sformatf("rmul%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
